// File: rtl/sdp_x_op_pkg.sv
// Shared widths, derived sizes and the FSM state type for the SDP X-stage operand feeder.
// Optional build macro used by the feeder: SDP_OP_FEEDER_PERF_EN.
package sdp_x_op_pkg;

    localparam int LANES   = 2;
    localparam int OP_DW   = 16;
    localparam int VEC_DW  = LANES * OP_DW;
    localparam int WORD_DW = 2 * VEC_DW;
    localparam int REP_W   = 13;
    localparam int BEAT_W  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // DMA words in a layer: one per vector pair when both streams share a word,
    // otherwise two vectors of the single live stream are packed per word.
    function automatic logic [BEAT_W-1:0] words_needed(input logic both_en,
                                                       input logic [BEAT_W-1:0] beat_total);
        if (both_en) begin
            return beat_total;
        end
        return {1'b0, beat_total[BEAT_W-1:1]} + {{(BEAT_W-1){1'b0}}, beat_total[0]};
    endfunction

endpackage

// File: rtl/sdp_x_op_stream_seq.sv
// Per-stream presentation sequencer: repeat counter, half select, remaining vectors,
// word-done flag and valid generation for one operand stream.
module sdp_x_op_stream_seq
    import sdp_x_op_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [BEAT_W-1:0] load_beats_i,
    input  logic              en_i,
    input  logic              pair_mode_i,
    input  logic [REP_W-1:0]  repeat_i,
    input  logic              buf_vld_i,
    input  logic              word_load_i,
    input  logic              prdy_i,
    output logic              pvld_o,
    output logic              sel_hi_o,
    output logic              retire_o,
    output logic              last_o
);

    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              half_q, half_d;
    logic              word_done_q, word_done_d;
    logic [BEAT_W-1:0] beats_left_q, beats_left_d;
    logic              hs, last_rep, vec_fin, to_high;

    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        pvld_o   = en_i & buf_vld_i & ~word_done_q & (beats_left_q != '0);
        hs       = pvld_o & prdy_i;
        last_rep = (rep_cnt_q == repeat_i);
        vec_fin  = hs & last_rep;
        // The high half is only live if the layer still has a vector beyond this one.
        to_high  = pair_mode_i & ~half_q & (beats_left_q > BEAT_W'(1));
        retire_o = ~en_i | word_done_q | (vec_fin & ~to_high);
        last_o   = (beats_left_q == '0) | (vec_fin & (beats_left_q == BEAT_W'(1)));
        sel_hi_o = half_q;

        rep_cnt_d    = rep_cnt_q;
        half_d       = half_q;
        word_done_d  = word_done_q;
        beats_left_d = beats_left_q;

        if (load_i) begin
            rep_cnt_d    = '0;
            half_d       = 1'b0;
            word_done_d  = 1'b0;
            beats_left_d = load_beats_i;
        end else begin
            if (hs) begin
                rep_cnt_d = last_rep ? '0 : rep_cnt_q + REP_W'(1);
            end
            if (vec_fin) begin
                beats_left_d = beats_left_q - BEAT_W'(1);
                half_d       = to_high;
                if (!to_high) begin
                    word_done_d = 1'b1;
                end
            end
            if (word_load_i) begin
                word_done_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rep_cnt_q    <= '0;
            half_q       <= 1'b0;
            word_done_q  <= 1'b0;
            beats_left_q <= '0;
        end else begin
            rep_cnt_q    <= rep_cnt_d;
            half_q       <= half_d;
            word_done_q  <= word_done_d;
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: rtl/sdp_x_op_feeder.sv
// SDP X-stage operand feeder: unpacks DMA operand words into ALU/MUL operand streams.
// Build macro SDP_OP_FEEDER_PERF_EN adds the perf_stall_cnt output.
module sdp_x_op_feeder
    import sdp_x_op_pkg::*;
(
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic               op_layer_start,
    input  logic               cfg_alu_en,
    input  logic               cfg_mul_en,
    input  logic [REP_W-1:0]   cfg_repeat,
    input  logic [BEAT_W-1:0]  cfg_beat_total,
    input  logic               dma_rd_pvld,
    output logic               dma_rd_prdy,
    input  logic [WORD_DW-1:0] dma_rd_data,
    output logic [VEC_DW-1:0]  chn_alu_op,
    output logic               chn_alu_op_pvld,
    input  logic               chn_alu_op_prdy,
    output logic [VEC_DW-1:0]  chn_mul_op,
    output logic               chn_mul_op_pvld,
    input  logic               chn_mul_op_prdy,
    output logic               op_layer_done
`ifdef SDP_OP_FEEDER_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt
`endif
);

    state_e              state_q, state_d;
    logic                alu_en_q, mul_en_q;
    logic [REP_W-1:0]    repeat_q;
    logic [BEAT_W-1:0]   words_left_q, words_left_d;
    logic [WORD_DW-1:0]  buf_q, buf_d;
    logic                buf_vld_q, buf_vld_d;

    logic                layer_load, layer_go, pair_mode;
    logic                accept, retire;
    logic [BEAT_W-1:0]   alu_load_beats, mul_load_beats;
    logic                alu_sel_hi, mul_sel_hi, mul_hi;
    logic                alu_retire, mul_retire, alu_last, mul_last;

    assign layer_load     = (state_q == IDLE) & op_layer_start;
    assign layer_go       = layer_load & (cfg_alu_en | cfg_mul_en) & (cfg_beat_total != '0);
    assign pair_mode      = alu_en_q ^ mul_en_q;
    assign alu_load_beats = (layer_go & cfg_alu_en) ? cfg_beat_total : '0;
    assign mul_load_beats = (layer_go & cfg_mul_en) ? cfg_beat_total : '0;

    assign retire      = buf_vld_q & alu_retire & mul_retire;
    assign dma_rd_prdy = (state_q == RUN) & (words_left_q != '0) & (~buf_vld_q | retire);
    assign accept      = dma_rd_pvld & dma_rd_prdy;

    sdp_x_op_stream_seq u_alu_seq (
        .clk_i        (nvdla_core_clk),
        .rst_i        (nvdla_core_rst),
        .load_i       (layer_load),
        .load_beats_i (alu_load_beats),
        .en_i         (alu_en_q),
        .pair_mode_i  (pair_mode),
        .repeat_i     (repeat_q),
        .buf_vld_i    (buf_vld_q),
        .word_load_i  (accept),
        .prdy_i       (chn_alu_op_prdy),
        .pvld_o       (chn_alu_op_pvld),
        .sel_hi_o     (alu_sel_hi),
        .retire_o     (alu_retire),
        .last_o       (alu_last)
    );

    sdp_x_op_stream_seq u_mul_seq (
        .clk_i        (nvdla_core_clk),
        .rst_i        (nvdla_core_rst),
        .load_i       (layer_load),
        .load_beats_i (mul_load_beats),
        .en_i         (mul_en_q),
        .pair_mode_i  (pair_mode),
        .repeat_i     (repeat_q),
        .buf_vld_i    (buf_vld_q),
        .word_load_i  (accept),
        .prdy_i       (chn_mul_op_prdy),
        .pvld_o       (chn_mul_op_pvld),
        .sel_hi_o     (mul_sel_hi),
        .retire_o     (mul_retire),
        .last_o       (mul_last)
    );

    // With both streams live, MUL always owns the high half of the word.
    assign mul_hi     = pair_mode ? mul_sel_hi : 1'b1;
    assign chn_alu_op = !alu_en_q ? '0 :
                        (alu_sel_hi ? buf_q[WORD_DW-1:VEC_DW] : buf_q[VEC_DW-1:0]);
    assign chn_mul_op = !mul_en_q ? '0 :
                        (mul_hi ? buf_q[WORD_DW-1:VEC_DW] : buf_q[VEC_DW-1:0]);

    assign op_layer_done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (layer_load) state_d = layer_go ? RUN : DONE;
            RUN:     if (alu_last & mul_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        words_left_d = words_left_q;
        buf_d        = buf_q;
        buf_vld_d    = buf_vld_q;
        if (layer_load) begin
            words_left_d = layer_go ? words_needed(cfg_alu_en & cfg_mul_en, cfg_beat_total) : '0;
        end else if (accept) begin
            words_left_d = words_left_q - BEAT_W'(1);
        end
        if (accept) begin
            buf_d     = dma_rd_data;
            buf_vld_d = 1'b1;
        end else if (retire) begin
            buf_vld_d = 1'b0;
        end
    end

    // NOTE: the word buffer is reset, not just its valid bit, because it drives the operand outputs.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q      <= IDLE;
            alu_en_q     <= 1'b0;
            mul_en_q     <= 1'b0;
            repeat_q     <= '0;
            words_left_q <= '0;
            buf_q        <= '0;
            buf_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            buf_q        <= buf_d;
            buf_vld_q    <= buf_vld_d;
            if (layer_load) begin
                alu_en_q <= cfg_alu_en;
                mul_en_q <= cfg_mul_en;
                repeat_q <= cfg_repeat;
            end
        end
    end

`ifdef SDP_OP_FEEDER_PERF_EN
    logic [31:0] perf_q;
    logic        stall;

    assign stall = (chn_alu_op_pvld & ~chn_alu_op_prdy) | (chn_mul_op_pvld & ~chn_mul_op_prdy);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            perf_q <= '0;
        end else if (layer_load) begin
            perf_q <= '0;
        end else if ((state_q == RUN) && stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    // Stall instrumentation is not built in this configuration.
`endif

endmodule

// File: tb/tb_sdp_x_op_feeder.sv
// Directed self-checking bench for sdp_x_op_feeder (SDP_OP_FEEDER_PERF_EN optional).
module tb_sdp_x_op_feeder;
    import sdp_x_op_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               op_layer_start;
    logic               cfg_alu_en, cfg_mul_en;
    logic [REP_W-1:0]   cfg_repeat;
    logic [BEAT_W-1:0]  cfg_beat_total;
    logic               dma_rd_pvld, dma_rd_prdy;
    logic [WORD_DW-1:0] dma_rd_data;
    logic [VEC_DW-1:0]  chn_alu_op, chn_mul_op;
    logic               chn_alu_op_pvld, chn_alu_op_prdy;
    logic               chn_mul_op_pvld, chn_mul_op_prdy;
    logic               op_layer_done;
`ifdef SDP_OP_FEEDER_PERF_EN
    logic [31:0]        perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    sdp_x_op_feeder dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rst  (rst),
        .op_layer_start  (op_layer_start),
        .cfg_alu_en      (cfg_alu_en),
        .cfg_mul_en      (cfg_mul_en),
        .cfg_repeat      (cfg_repeat),
        .cfg_beat_total  (cfg_beat_total),
        .dma_rd_pvld     (dma_rd_pvld),
        .dma_rd_prdy     (dma_rd_prdy),
        .dma_rd_data     (dma_rd_data),
        .chn_alu_op      (chn_alu_op),
        .chn_alu_op_pvld (chn_alu_op_pvld),
        .chn_alu_op_prdy (chn_alu_op_prdy),
        .chn_mul_op      (chn_mul_op),
        .chn_mul_op_pvld (chn_mul_op_pvld),
        .chn_mul_op_prdy (chn_mul_op_prdy),
        .op_layer_done   (op_layer_done)
`ifdef SDP_OP_FEEDER_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [WORD_DW-1:0] words[$];
    logic [VEC_DW-1:0]  alu_got[$];
    logic [VEC_DW-1:0]  mul_got[$];
    logic [VEC_DW-1:0]  alu_exp[$];
    logic [VEC_DW-1:0]  mul_exp[$];
    int alu_lo, alu_hi, mul_lo, mul_hi;
    int done_cyc, done_cnt, first_hs, last_hs, widx;
    int prdy_cnt, prdy_win_cnt, alu_pvld_win, mul_pvld_cnt, mul_nz, stab_err;

    task automatic start_layer(input logic a_en, input logic m_en,
                               input logic [REP_W-1:0] rep, input logic [BEAT_W-1:0] bt);
        @(negedge clk);
        cfg_alu_en     = a_en;
        cfg_mul_en     = m_en;
        cfg_repeat     = rep;
        cfg_beat_total = bt;
        op_layer_start = 1'b1;
    endtask

    // Cycle 0 is the first cycle after the edge that sampled op_layer_start.
    task automatic run_layer(input int budget, input bit expect_done);
        logic              pa_stall, pm_stall;
        logic [VEC_DW-1:0] pa, pm;
        pa_stall = 1'b0; pm_stall = 1'b0; pa = '0; pm = '0;
        alu_got.delete(); mul_got.delete();
        done_cyc = -1; done_cnt = 0; first_hs = -1; last_hs = -1; widx = 0;
        prdy_cnt = 0; prdy_win_cnt = 0; alu_pvld_win = 0; mul_pvld_cnt = 0; mul_nz = 0; stab_err = 0;
        for (int cyc = 0; cyc < budget && done_cnt == 0; cyc++) begin
            @(negedge clk);
            op_layer_start  = 1'b0;
            // Scramble live config: the layer must run from its shadow copy.
            cfg_alu_en      = ~cfg_alu_en;
            cfg_mul_en      = ~cfg_mul_en;
            cfg_repeat      = 13'h0abc;
            cfg_beat_total  = 24'h00f00f;
            dma_rd_pvld     = (widx < words.size());
            dma_rd_data     = dma_rd_pvld ? words[widx] : '0;
            chn_alu_op_prdy = !(cyc >= alu_lo && cyc <= alu_hi);
            chn_mul_op_prdy = !(cyc >= mul_lo && cyc <= mul_hi);
            #1;
            if (op_layer_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dma_rd_prdy) prdy_cnt++;
            if (dma_rd_prdy && cyc >= mul_lo && cyc <= mul_hi) prdy_win_cnt++;
            if (chn_alu_op_pvld && cyc > mul_lo && cyc <= mul_hi) alu_pvld_win++;
            if (chn_mul_op_pvld) mul_pvld_cnt++;
            if (chn_mul_op != '0) mul_nz++;
            if (pa_stall && (!chn_alu_op_pvld || chn_alu_op !== pa)) stab_err++;
            if (pm_stall && (!chn_mul_op_pvld || chn_mul_op !== pm)) stab_err++;
            pa_stall = chn_alu_op_pvld && !chn_alu_op_prdy;
            pm_stall = chn_mul_op_pvld && !chn_mul_op_prdy;
            pa = chn_alu_op;
            pm = chn_mul_op;
            if (chn_alu_op_pvld && chn_alu_op_prdy) begin
                alu_got.push_back(chn_alu_op);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (chn_mul_op_pvld && chn_mul_op_prdy) begin
                mul_got.push_back(chn_mul_op);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (dma_rd_pvld && dma_rd_prdy) widx++;
        end
        if (expect_done) begin
            checks++;
            if (done_cnt == 0) begin
                failures++;
                $display("FAIL layer_timeout: no op_layer_done within %0d cycles", budget);
            end
        end
        chn_alu_op_prdy = 1'b0;
        chn_mul_op_prdy = 1'b0;
        dma_rd_pvld     = 1'b0;
    endtask

    task automatic compare_streams(input string tag);
        checks++;
        if (alu_got.size() !== alu_exp.size()) begin
            failures++;
            $display("FAIL %s alu_count: got %0d expected %0d", tag, alu_got.size(), alu_exp.size());
        end
        checks++;
        if (mul_got.size() !== mul_exp.size()) begin
            failures++;
            $display("FAIL %s mul_count: got %0d expected %0d", tag, mul_got.size(), mul_exp.size());
        end
        for (int i = 0; i < alu_exp.size() && i < alu_got.size(); i++) begin
            checks++;
            if (alu_got[i] !== alu_exp[i]) begin
                failures++;
                $display("FAIL %s alu_data[%0d]: got %h expected %h", tag, i, alu_got[i], alu_exp[i]);
            end
        end
        for (int i = 0; i < mul_exp.size() && i < mul_got.size(); i++) begin
            checks++;
            if (mul_got[i] !== mul_exp[i]) begin
                failures++;
                $display("FAIL %s mul_data[%0d]: got %h expected %h", tag, i, mul_got[i], mul_exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({dma_rd_prdy, chn_alu_op_pvld, chn_mul_op_pvld, op_layer_done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {dma_rd_prdy, chn_alu_op_pvld, chn_mul_op_pvld, op_layer_done});
        end
        checks++;
        if ({chn_alu_op, chn_mul_op} !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {chn_alu_op, chn_mul_op});
        end
        rst = 1'b0;
    endtask

    task automatic test_both_streams();
        words = '{64'h1111_0001_2222_0002, 64'h3333_0003_4444_0004,
                  64'h5555_0005_6666_0006, 64'h7777_0007_8888_0008};
        alu_exp = '{32'h2222_0002, 32'h4444_0004, 32'h6666_0006, 32'h8888_0008};
        mul_exp = '{32'h1111_0001, 32'h3333_0003, 32'h5555_0005, 32'h7777_0007};
        start_layer(1'b1, 1'b1, 13'd0, 24'd4);
        run_layer(40, 1'b1);
        compare_streams("both");
        checks++;
        if (done_cyc !== 5 || last_hs !== 4) begin
            failures++;
            $display("FAIL both_done_cycle: got done=%0d last_hs=%0d expected 5 and 4", done_cyc, last_hs);
        end
        checks++;
        if (last_hs - first_hs !== 3) begin
            failures++;
            $display("FAIL both_zero_bubble: got span %0d expected 3", last_hs - first_hs);
        end
        @(negedge clk); #1;
        checks++;
        if (op_layer_done !== 1'b0) begin
            failures++;
            $display("FAIL both_done_pulse_width: got %b expected 0", op_layer_done);
        end
    endtask

    task automatic test_alu_only_repeat();
        words = '{64'hAAAA_0001_A1A1_1010, 64'hDEAD_BEEF_A2A2_2020, 64'hFFFF_FFFF_FFFF_FFFF};
        alu_exp = '{32'hA1A1_1010, 32'hA1A1_1010, 32'hA1A1_1010,
                    32'hAAAA_0001, 32'hAAAA_0001, 32'hAAAA_0001,
                    32'hA2A2_2020, 32'hA2A2_2020, 32'hA2A2_2020};
        mul_exp.delete();
        start_layer(1'b1, 1'b0, 13'd2, 24'd3);
        run_layer(60, 1'b1);
        compare_streams("alu_only");
        checks++;
        if (widx !== 2) begin
            failures++;
            $display("FAIL alu_only_words: got %0d expected 2", widx);
        end
        checks++;
        if (mul_pvld_cnt !== 0 || mul_nz !== 0) begin
            failures++;
            $display("FAIL alu_only_mul_idle: got pvld=%0d nonzero=%0d expected 0 and 0", mul_pvld_cnt, mul_nz);
        end
        checks++;
        if (done_cyc !== 10) begin
            failures++;
            $display("FAIL alu_only_done_cycle: got %0d expected 10", done_cyc);
        end
    endtask

    task automatic test_mul_backpressure();
        words = '{64'h0B0B_0B0B_0A0A_0A0A, 64'h1B1B_1B1B_1A1A_1A1A};
        alu_exp = '{32'h0A0A_0A0A, 32'h1A1A_1A1A};
        mul_exp = '{32'h0B0B_0B0B, 32'h1B1B_1B1B};
        mul_lo = 1; mul_hi = 10;
        start_layer(1'b1, 1'b1, 13'd0, 24'd2);
        run_layer(60, 1'b1);
        mul_lo = -1; mul_hi = -2;
        compare_streams("backpressure");
        checks++;
        if (prdy_win_cnt !== 0) begin
            failures++;
            $display("FAIL bp_dma_prdy: got %0d ready cycles expected 0", prdy_win_cnt);
        end
        checks++;
        if (alu_pvld_win !== 0) begin
            failures++;
            $display("FAIL bp_alu_wait: got %0d valid cycles expected 0", alu_pvld_win);
        end
        checks++;
        if (stab_err !== 0) begin
            failures++;
            $display("FAIL bp_data_stable: got %0d violations expected 0", stab_err);
        end
        checks++;
        if (done_cyc !== 13) begin
            failures++;
            $display("FAIL bp_done_cycle: got %0d expected 13", done_cyc);
        end
    endtask

    task automatic test_degenerate();
        words = '{64'h0123_4567_89AB_CDEF};
        for (int k = 0; k < 2; k++) begin
            if (k == 0) start_layer(1'b1, 1'b1, 13'd1, 24'd0);
            else        start_layer(1'b0, 1'b0, 13'd1, 24'd5);
            run_layer(10, 1'b1);
            checks++;
            if (done_cyc !== 0 || prdy_cnt !== 0 || widx !== 0) begin
                failures++;
                $display("FAIL degenerate_%0d: got done=%0d prdy=%0d words=%0d expected 0 0 0",
                         k, done_cyc, prdy_cnt, widx);
            end
        end
    endtask

    task automatic test_reset_mid_layer();
        words = '{64'h9999_0009_8888_0008, 64'h7777_0007_6666_0006};
        start_layer(1'b1, 1'b1, 13'd3, 24'd2);
        run_layer(3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({dma_rd_prdy, chn_alu_op_pvld, chn_mul_op_pvld, op_layer_done} !== 4'b0) begin
            failures++;
            $display("FAIL midreset_ctrl: got %b expected 0000",
                     {dma_rd_prdy, chn_alu_op_pvld, chn_mul_op_pvld, op_layer_done});
        end
        checks++;
        if ({chn_alu_op, chn_mul_op} !== '0) begin
            failures++;
            $display("FAIL midreset_data: got %h expected 0", {chn_alu_op, chn_mul_op});
        end
        @(negedge clk);
        rst = 1'b0;
        alu_exp = '{32'h8888_0008, 32'h8888_0008, 32'h6666_0006, 32'h6666_0006};
        mul_exp = '{32'h9999_0009, 32'h9999_0009, 32'h7777_0007, 32'h7777_0007};
        start_layer(1'b1, 1'b1, 13'd1, 24'd2);
        run_layer(40, 1'b1);
        compare_streams("after_reset");
        checks++;
        if (done_cyc !== 5) begin
            failures++;
            $display("FAIL after_reset_done_cycle: got %0d expected 5", done_cyc);
        end
    endtask

`ifdef SDP_OP_FEEDER_PERF_EN
    task automatic test_perf();
        words = '{64'h0000_00B1_0000_00A1};
        mul_lo = 1; mul_hi = 5;
        start_layer(1'b1, 1'b1, 13'd0, 24'd1);
        run_layer(30, 1'b1);
        mul_lo = -1; mul_hi = -2;
        checks++;
        if (perf_stall_cnt !== 32'd5) begin
            failures++;
            $display("FAIL perf_count: got %0d expected 5", perf_stall_cnt);
        end
        start_layer(1'b1, 1'b1, 13'd0, 24'd0);
        run_layer(10, 1'b1);
        checks++;
        if (perf_stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_clear: got %0d expected 0", perf_stall_cnt);
        end
    endtask
`endif

    initial begin
        rst             = 1'b1;
        op_layer_start  = 1'b0;
        cfg_alu_en      = 1'b0;
        cfg_mul_en      = 1'b0;
        cfg_repeat      = '0;
        cfg_beat_total  = '0;
        dma_rd_pvld     = 1'b0;
        dma_rd_data     = '0;
        chn_alu_op_prdy = 1'b0;
        chn_mul_op_prdy = 1'b0;
        alu_lo = -1; alu_hi = -2; mul_lo = -1; mul_hi = -2;

        test_reset();
        test_both_streams();
        test_alu_only_repeat();
        test_mul_backpressure();
        test_degenerate();
        test_reset_mid_layer();
`ifdef SDP_OP_FEEDER_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
